// File: rtl/rnn_input_sequencer_if.sv
// Stream, datapath and result bus bundle for rnn_input_sequencer.
// slave  : view of the sequencer itself.
// master : view of the surroundings (upstream source, datapath, downstream sink).
//
// Handshake semantics (both s_* and m_* channels):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   The producer keeps valid high and data stable until the transfer happens.
//   ready may be asserted or withdrawn at any time and has no effect while valid is low.
interface rnn_input_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [2:0]        rnn_sel;
  logic [DATA_W-1:0] rnn_in;
  logic [DATA_W-1:0] rnn_out;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport slave (
    input  s_valid, s_data, rnn_out, m_ready,
    output s_ready, rnn_sel, rnn_in, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, rnn_out, m_ready,
    input  s_ready, rnn_sel, rnn_in, m_valid, m_data
  );
endinterface

// File: rtl/rnn_input_sequencer.sv
// rnn_input_sequencer: groups 8 stream words into one RNN input vector, writes them
// into the datapath operand registers via rnn_sel/rnn_in, waits SETTLE_CYCLES for the
// neuron output to settle, captures rnn_out and offers it downstream.
// The datapath writes rnn_in into x[rnn_sel] on every clock, so rnn_sel/rnn_in only
// change when a word is accepted; otherwise the same word is rewritten harmlessly.
// Optional feature macro: RNN_SEQ_PERF_EN adds the perf_vec_count result counter.
// fsm_state exposes the FSM state (LOAD=0, SETTLE=1, RESULT=2) for observation.
module rnn_input_sequencer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2   // legal range 2..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  rnn_input_sequencer_if.slave bus,
  output logic                 busy,
  output logic [1:0]           fsm_state
`ifdef RNN_SEQ_PERF_EN
  ,
  output logic [15:0]          perf_vec_count
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [2:0]        idx;
  logic [3:0]        settle_cnt;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] in_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;

  // control strobes decoded from state and inputs
  logic s_ready_c;
  logic load_word;
  logic capture;
  logic result_done;
  logic flush;
  logic settle_run;

  // next-state and strobe decode; abort only matters in LOAD and SETTLE
  always_comb begin
    state_next  = state;
    s_ready_c   = 1'b0;
    load_word   = 1'b0;
    capture     = 1'b0;
    result_done = 1'b0;
    flush       = 1'b0;
    settle_run  = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready_c = !abort;
        if (abort) begin
          flush = 1'b1;
        end else if (bus.s_valid) begin
          load_word = 1'b1;
          if (idx == 3'd7) begin
            state_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = ST_LOAD;
        end else if (settle_cnt == SETTLE_LAST) begin
          capture    = 1'b1;
          state_next = ST_RESULT;
        end else begin
          settle_run = 1'b1;
        end
      end
      ST_RESULT: begin
        if (m_valid_q && bus.m_ready) begin
          result_done = 1'b1;
          state_next  = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // word index: advances per accepted word, cleared by flush or result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 3'd0;
    end else if (flush || result_done) begin
      idx <= 3'd0;
    end else if (load_word) begin
      idx <= idx + 3'd1;
    end
  end

  // settle counter: counts while in SETTLE, parked at zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
    end else if (settle_run) begin
      settle_cnt <= settle_cnt + 4'd1;
    end else begin
      settle_cnt <= 4'd0;
    end
  end

  // operand bus: written only on an accepted word, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 3'd0;
      in_q  <= '0;
    end else if (load_word) begin
      sel_q <= idx;
      in_q  <= bus.s_data;
    end
  end

  // result register: captured once per vector, held until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (capture) begin
      m_valid_q <= 1'b1;
      m_data_q  <= bus.rnn_out;
    end else if (result_done) begin
      m_valid_q <= 1'b0;
    end
  end

`ifdef RNN_SEQ_PERF_EN
  logic [15:0] perf_cnt_q;

  // delivered-result counter; wraps naturally, untouched by abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= 16'd0;
    end else if (result_done) begin
      perf_cnt_q <= perf_cnt_q + 16'd1;
    end
  end

  assign perf_vec_count = perf_cnt_q;
`endif

  assign bus.s_ready = s_ready_c;
  assign bus.rnn_sel = sel_q;
  assign bus.rnn_in  = in_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign busy        = (state != ST_LOAD) || (idx != 3'd0);
  assign fsm_state   = state;

endmodule

// File: tb/tb_rnn_input_sequencer.sv
// Bench for rnn_input_sequencer with a behavioural 8-operand datapath model.
module tb_rnn_input_sequencer;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              abort;
  logic              busy;
  logic [1:0]        fsm_state;
`ifdef RNN_SEQ_PERF_EN
  logic [15:0]       perf_vec_count;
`endif

  rnn_input_sequencer_if #(.DATA_W(DATA_W)) bus ();

  rnn_input_sequencer #(.DATA_W(DATA_W), .SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .fsm_state (fsm_state)
`ifdef RNN_SEQ_PERF_EN
    ,
    .perf_vec_count (perf_vec_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  logic [DATA_W-1:0] x [8];

  function automatic logic [DATA_W-1:0] neuron8(input logic [DATA_W-1:0] w [8]);
    logic [DATA_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) acc = acc + DATA_W'(k + 1) * w[k];
    return acc;
  endfunction

  always @(posedge clk) x[bus.rnn_sel] <= bus.rnn_in;
  always_comb bus.rnn_out = neuron8(x);

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] words [8];
  int                wcnt;
  int                n_vec;
  int                n_err;
  int                n_res;
  logic              rand_mode;

  // result monitor: every downstream transfer is checked against the queue head
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      n_vec++;
      n_res++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got %h, expected no result", bus.m_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.m_data !== e) begin
          n_err++;
          $display("FAIL result_data: got %h, expected %h", bus.m_data, e);
        end
      end
    end
  end

  // random downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DATA_W-1:0] d, input int gap, input bit hold);
    int t;
    if (gap > 0) begin
      bus.s_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_ready && t < 200);
    if (!bus.s_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL s_ready_timeout: s_ready=%b, expected 1 within 200 cycles", bus.s_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.s_valid = 1'b0;
    words[wcnt] = d;
    wcnt++;
    if (wcnt == 8) begin
      exp_q.push_back(neuron8(words));
      wcnt = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0 || bus.m_valid) begin
      n_err++;
      $display("FAIL %s_drain: %0d results outstanding, m_valid=%b, expected 0/0", name, exp_q.size(), bus.m_valid);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    exp_q.delete();
    wcnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (bus.m_valid !== 1'b0 || bus.rnn_sel !== 3'd0 || bus.rnn_in !== '0 ||
        busy !== 1'b0 || bus.m_data !== '0) begin
      n_err++;
      $display("FAIL %s: m_valid=%b sel=%0d in=%h busy=%b m_data=%h, expected all zero",
               name, bus.m_valid, bus.rnn_sel, bus.rnn_in, busy, bus.m_data);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    check_idle("reset_state");
    n_vec++;
    if (bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_s_ready: got %b, expected 1", bus.s_ready);
    end
  endtask

  task automatic test_stream();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_word(DATA_W'(k + 1), 0, k != 7);
      n_vec++;
      if (bus.rnn_sel !== 3'(k) || bus.rnn_in !== DATA_W'(k + 1)) begin
        n_err++;
        $display("FAIL stream_operand%0d: sel=%0d in=%h, expected sel=%0d in=%h",
                 k, bus.rnn_sel, bus.rnn_in, k, k + 1);
      end
    end
    n_vec++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_after_last: s_ready=%b m_valid=%b, expected 0/0", bus.s_ready, bus.m_valid);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_latency_early: m_valid=%b one edge after last word, expected 0", bus.m_valid);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== DATA_W'(204)) begin
      n_err++;
      $display("FAIL stream_latency: m_valid=%b m_data=%h two edges after last word, expected 1/%h",
               bus.m_valid, bus.m_data, 204);
    end
    wait_drain("stream");
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] held;
    int t;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_word(DATA_W'(32'h100 + k), 0, k != 7);
    t = 0;
    while (!bus.m_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    held = bus.m_data;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h5555;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== held || bus.s_ready !== 1'b0 ||
          bus.rnn_sel !== 3'd7 || bus.rnn_in !== DATA_W'(32'h107) || x[7] !== DATA_W'(32'h107)) begin
        n_err++;
        $display("FAIL hold_cycle%0d: m_valid=%b m_data=%h s_ready=%b sel=%0d in=%h x8=%h, expected 1/%h/0/7/107/107",
                 c, bus.m_valid, bus.m_data, bus.s_ready, bus.rnn_sel, bus.rnn_in, x[7], held);
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain("hold");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k++) send_word(DATA_W'(32'h200 + k), 1, 1'b0);
    abort       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD;
    @(negedge clk);
    n_vec++;
    if (bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_s_ready: got %b, expected 0", bus.s_ready);
    end
    @(posedge clk);
    #1;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    wcnt        = 0;
    n_vec++;
    if (bus.rnn_sel !== 3'd2 || bus.rnn_in !== DATA_W'(32'h202) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_hold: sel=%0d in=%h busy=%b, expected 2/202/0", bus.rnn_sel, bus.rnn_in, busy);
    end
    for (int k = 0; k < 8; k++) send_word(DATA_W'(32'hA0 + k), 0, k != 7);
    wait_drain("abort");
  endtask

  task automatic test_random();
    int start_res;
    start_res = n_res;
    rand_mode = 1'b1;
    for (int v = 0; v < 200; v++) begin
      for (int k = 0; k < 8; k++) send_word($urandom(), $urandom_range(0, 2), 1'b0);
    end
    wait_drain("random");
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    n_vec++;
    if (n_res - start_res != 200) begin
      n_err++;
      $display("FAIL random_count: got %0d results, expected 200", n_res - start_res);
    end
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) send_word(DATA_W'(32'h300 + k), 0, k != 7);
    rst_n = 1'b0;
    exp_q.delete();
    wcnt = 0;
    #1;
    check_idle("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) send_word(DATA_W'(32'h400 + 3 * k), 0, k != 7);
    wait_drain("reset_mid");
  endtask

`ifdef RNN_SEQ_PERF_EN
  task automatic test_perf();
    force dut.perf_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.perf_cnt_q;
    bus.m_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 8; k++) send_word(DATA_W'(32'h500 + v * 8 + k), 0, k != 7);
    end
    wait_drain("perf");
    n_vec++;
    if (perf_vec_count !== 16'h0001) begin
      n_err++;
      $display("FAIL perf_wrap: got %h, expected 0001", perf_vec_count);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    n_res     = 0;
    wcnt      = 0;
    rand_mode = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_abort();
    test_random();
    test_reset_mid();
`ifdef RNN_SEQ_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
